// File: rtl/dht11_ctrl.sv
// DHT11 single-wire transaction controller: start pulse, response wait, frame receive, checksum.
// Optional retry on failure is enabled by defining DHT11_RETRY_EN.
module dht11_ctrl #(
  parameter int unsigned CLK_PER_US  = 100,
  parameter int unsigned START_LO_US = 18000,
  parameter int unsigned REL_US      = 40,
  parameter int unsigned RX_TO_US    = 6000,
  parameter int unsigned GUARD_US    = 1000000,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        auto_en,
  input  logic        dq_in,
  output logic        dq_oe,
  output logic        parse_rst,
  output logic        parse_en,
  input  logic [39:0] frame,
  input  logic        frame_done,
  output logic        busy,
  output logic [15:0] hum,
  output logic [15:0] temp,
  output logic        valid,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int unsigned START_CYC = START_LO_US * CLK_PER_US;
  localparam int unsigned REL_CYC   = REL_US * CLK_PER_US;
  localparam int unsigned RX_CYC    = RX_TO_US * CLK_PER_US;
  localparam int unsigned GUARD_CYC = GUARD_US * CLK_PER_US;
  localparam int unsigned PH_MAX    = (START_CYC > RX_CYC) ?
                                      ((START_CYC > REL_CYC) ? START_CYC : REL_CYC) :
                                      ((RX_CYC > REL_CYC) ? RX_CYC : REL_CYC);
  localparam int unsigned CW = $clog2(PH_MAX + 1);
  localparam int unsigned GW = $clog2(GUARD_CYC + 1);
  localparam int unsigned RW = $clog2(MAX_RETRY + 2);
`ifdef DHT11_RETRY_EN
  localparam int unsigned RETRY_LIM = MAX_RETRY;
`else
  localparam int unsigned RETRY_LIM = 0;
`endif

  localparam logic [CW-1:0] START_LAST = CW'(START_CYC - 1);
  localparam logic [CW-1:0] REL_LAST   = CW'(REL_CYC - 1);
  localparam logic [CW-1:0] RX_LAST    = CW'(RX_CYC - 1);
  localparam logic [GW-1:0] GUARD_LIM  = GW'(GUARD_CYC);
  // Preloaded with 2 so that the GUARD->IDLE->START_LO hops make start-to-start spacing exactly GUARD_CYC.
  localparam logic [GW-1:0] GUARD_PRE  = GW'(2);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(RETRY_LIM);

  typedef enum logic [2:0] {IDLE, START_LO, RELEASE, RECV, CHECK, GUARD} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] guard_q, guard_d;
  logic [RW-1:0] retry_q, retry_d;
  logic        pend_q, pend_d;
  logic [39:0] frame_q, frame_d;
  logic [15:0] hum_q, hum_d, temp_q, temp_d;
  logic        valid_q, valid_d, err_q, err_d;
  logic [1:0]  code_q, code_d;

  logic        guard_exp, start, pass, fail, final_fail, sum_ok;
  logic [1:0]  fail_code;
  logic [7:0]  sum;

  assign guard_exp = (guard_q == GUARD_LIM);
  assign sum       = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];
  assign sum_ok    = (sum == frame_q[7:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      guard_q <= GUARD_LIM;
      retry_q <= '0;
      pend_q  <= 1'b0;
      frame_q <= '0;
      hum_q   <= '0;
      temp_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      guard_q <= guard_d;
      retry_q <= retry_d;
      pend_q  <= pend_d;
      frame_q <= frame_d;
      hum_q   <= hum_d;
      temp_q  <= temp_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    start     = 1'b0;
    pass      = 1'b0;
    fail      = 1'b0;
    fail_code = 2'b00;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req || pend_q || (auto_en && guard_exp)) begin
          state_d = START_LO;
          start   = 1'b1;
        end
      end
      START_LO: if (cnt_q == START_LAST) begin
        state_d = RELEASE;
        cnt_d   = '0;
      end
      RELEASE: begin
        if (!dq_in) begin
          state_d = RECV;
          cnt_d   = '0;
        end else if (cnt_q == REL_LAST) begin
          fail      = 1'b1;
          fail_code = 2'b01;
        end
      end
      RECV: begin
        if (frame_done) begin
          state_d = CHECK;
          cnt_d   = '0;
        end else if (cnt_q == RX_LAST) begin
          fail      = 1'b1;
          fail_code = 2'b10;
        end
      end
      CHECK: begin
        pass      = sum_ok;
        fail      = !sum_ok;
        fail_code = 2'b11;
      end
      GUARD: begin
        cnt_d = '0;
        if (guard_exp) begin
          // A non-zero retry count here means a failed attempt is waiting to be re-run.
          if (retry_q != '0) begin
            state_d = START_LO;
            start   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (pass || fail) begin
      state_d = GUARD;
      cnt_d   = '0;
    end
  end

  always_comb begin
    final_fail = fail && (retry_q == RETRY_MAX);
    guard_d    = start ? GUARD_PRE : (guard_exp ? guard_q : guard_q + GW'(1));
    pend_d     = (pend_q && !(start && state_q == IDLE)) || (req && state_q != IDLE);
    retry_d    = retry_q;
    if (pass || final_fail)
      retry_d = '0;
    else if (fail)
      retry_d = retry_q + RW'(1);
    frame_d = (state_q == RECV && frame_done) ? frame : frame_q;
    hum_d   = pass ? frame_q[39:24] : hum_q;
    temp_d  = pass ? frame_q[23:8] : temp_q;
    valid_d = pass;
    err_d   = final_fail;
    code_d  = pass ? 2'b00 : (final_fail ? fail_code : code_q);
  end

  always_comb begin
    dq_oe     = (state_q == START_LO);
    parse_en  = (state_q == RECV);
    parse_rst = (state_q != RECV);
    busy      = (state_q != IDLE);
  end

  assign hum      = hum_q;
  assign temp     = temp_q;
  assign valid    = valid_q;
  assign err      = err_q;
  assign err_code = code_q;

endmodule
